// File: rtl/mips_reg_writeback_if.sv
// Producer-side handshake bundle for mips_reg_writeback: ALU result path and load result path.
interface mips_reg_writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_byte_off;
  logic [1:0]  mem_size;
  logic        mem_signed;

  modport master (
    output alu_valid, alu_dest, alu_result,
    output mem_valid, mem_dest, mem_rdata, mem_byte_off, mem_size, mem_signed,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_dest, alu_result,
    input  mem_valid, mem_dest, mem_rdata, mem_byte_off, mem_size, mem_signed,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/mips_reg_writeback.sv
// Register-file write driver: extends loads, queues results in a DEPTH-entry FIFO, retires one per cycle.
// Optional WB_BYPASS_EN adds two combinational forwarding lookups over the output register and FIFO.
module mips_reg_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_stall,
  mips_reg_writeback_if.slave    bus,
  output logic                   RegWrite,
  output logic [4:0]             write_addr,
  output logic [31:0]            write_data,
  output logic                   load_misalign,
  output logic [$clog2(DEPTH):0] pending_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]             byp_addr_1,
  input  logic [4:0]             byp_addr_2,
  output logic                   byp_hit_1,
  output logic                   byp_hit_2,
  output logic [31:0]            byp_data_1,
  output logic [31:0]            byp_data_2
`endif
);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, mem_fire, alu_fire, misalign, push, pop;
  logic [4:0]    push_dest;
  logic [31:0]   push_data, load_data;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign full          = (pending_cnt == (PW+1)'(DEPTH));
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign mem_fire      = bus.mem_valid && !full;
  assign alu_fire      = bus.alu_valid && bus.alu_ready;
  // size 11 decodes as word through mem_size[1]
  assign misalign      = ((bus.mem_size == 2'b01) && bus.mem_byte_off[0]) ||
                         (bus.mem_size[1] && (bus.mem_byte_off != 2'b00));
  assign push          = (mem_fire && !misalign) || alu_fire;
  assign pop           = !wb_stall && (pending_cnt != '0);

  always_comb begin
    lane_b = bus.mem_rdata[{bus.mem_byte_off, 3'b000} +: 8];
    lane_h = bus.mem_byte_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (bus.mem_size)
      2'b00:   load_data = {{24{bus.mem_signed & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{bus.mem_signed & lane_h[15]}}, lane_h};
      default: load_data = bus.mem_rdata;
    endcase
    push_dest = mem_fire ? bus.mem_dest : bus.alu_dest;
    push_data = mem_fire ? load_data    : bus.alu_result;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr] <= push_dest;
      data_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pending_cnt   <= '0;
      RegWrite      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      load_misalign <= 1'b0;
    end else begin
      load_misalign <= mem_fire && misalign;
      RegWrite      <= pop && (dest_q[rd_ptr] != 5'd0);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        // $zero entries consume the slot but leave the output registers untouched
        if (dest_q[rd_ptr] != 5'd0) begin
          write_addr <= dest_q[rd_ptr];
          write_data <= data_q[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   pending_cnt <= pending_cnt + (PW+1)'(1);
        2'b01:   pending_cnt <= pending_cnt - (PW+1)'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Oldest FIFO entry checked first so younger matches and then the output register override it.
  function automatic logic [32:0] byp_lookup(input logic [4:0] a);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      idx = wr_ptr - PW'(i) - PW'(1);
      if (((PW+1)'(i) < pending_cnt) && (dest_q[idx] == a)) r = {1'b1, data_q[idx]};
    end
    if (RegWrite && (write_addr == a)) r = {1'b1, write_data};
    if (a == 5'd0) r = '0;
    return r;
  endfunction

  assign {byp_hit_1, byp_data_1} = byp_lookup(byp_addr_1);
  assign {byp_hit_2, byp_data_2} = byp_lookup(byp_addr_2);
`endif
endmodule

// File: tb/tb_mips_reg_writeback.sv
// Self-checking bench for mips_reg_writeback: directed sequences, load-extension table, randomized model run.
module tb_mips_reg_writeback;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, wb_stall;
  logic        RegWrite, load_misalign;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [$clog2(DEPTH):0] pending_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_addr_1, byp_addr_2;
  logic        byp_hit_1, byp_hit_2;
  logic [31:0] byp_data_1, byp_data_2;
`endif

  mips_reg_writeback_if bus ();

  mips_reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall), .bus(bus.slave),
    .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data),
    .load_misalign(load_misalign), .pending_cnt(pending_cnt)
`ifdef WB_BYPASS_EN
    , .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] data;
    logic        mis;
  } ld_vec_t;
  ld_vec_t tbl[$];

  typedef struct { logic [4:0] d; logic [31:0] v; } ent_t;
  ent_t        q[$];
  logic        exp_we, exp_mis;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  // Reference extension: shift the addressed bytes down, mask to the access width, then extend.
  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input int off, input int size, input bit sgn);
    logic [31:0] sh, v;
    sh = rd >> (8 * off);
    if (size == 0) begin
      v = sh & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = sh & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [32:0] ref_byp(input logic [4:0] a);
    if (a == 0) return '0;
    if (exp_we && exp_addr == a) return {1'b1, exp_data};
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].d == a) return {1'b1, q[i].v};
    return '0;
  endfunction

  initial begin
    rst = 1'b1; wb_stall = 1'b0;
    bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_result = 0;
    bus.mem_valid = 0; bus.mem_dest = 0; bus.mem_rdata = 0;
    bus.mem_byte_off = 0; bus.mem_size = 0; bus.mem_signed = 0;
`ifdef WB_BYPASS_EN
    byp_addr_1 = 0; byp_addr_2 = 0;
`endif

    // reset held two cycles with an ALU result offered
    bus.alu_valid = 1; bus.alu_dest = 5'd3; bus.alu_result = 32'h1111_1111;
    tick; tick;
    chk("rst_we", RegWrite, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_mis", load_misalign, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    bus.alu_valid = 0; rst = 1'b0;
    tick;

    // ALU push latency
    bus.alu_valid = 1; bus.alu_dest = 5'd5; bus.alu_result = 32'hDEAD_BEEF;
    tick;
    bus.alu_valid = 0;
    chk("alu_we_n", RegWrite, 0);
    chk("alu_cnt_n", pending_cnt, 1);
    tick;
    chk("alu_we", RegWrite, 1);
    chk("alu_addr", write_addr, 5);
    chk("alu_data", write_data, 32'hDEAD_BEEF);
    tick;
    chk("alu_we_1cyc", RegWrite, 0);
    chk("alu_hold", write_data, 32'hDEAD_BEEF);

    // load extension / misalignment table
    tbl.push_back('{32'h8081_82F3, 2'd0, 2'b00, 1'b1, 32'hFFFF_FFF3, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd1, 2'b00, 1'b0, 32'h0000_0082, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd2, 2'b00, 1'b1, 32'hFFFF_FF81, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd3, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd0, 2'b01, 1'b1, 32'hFFFF_82F3, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd2, 2'b01, 1'b0, 32'h0000_8081, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd2, 2'b01, 1'b1, 32'hFFFF_8081, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd0, 2'b10, 1'b1, 32'h8081_82F3, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd0, 2'b11, 1'b0, 32'h8081_82F3, 1'b0});
    tbl.push_back('{32'h1234_5678, 2'd1, 2'b00, 1'b1, 32'h0000_0056, 1'b0});
    tbl.push_back('{32'h1234_5678, 2'd0, 2'b01, 1'b1, 32'h0000_5678, 1'b0});
    tbl.push_back('{32'h8081_82F3, 2'd1, 2'b01, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{32'h8081_82F3, 2'd3, 2'b01, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{32'h8081_82F3, 2'd2, 2'b10, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{32'h8081_82F3, 2'd1, 2'b11, 1'b0, 32'h0, 1'b1});
    foreach (tbl[i]) begin
      bus.mem_valid = 1; bus.mem_dest = 5'd9; bus.mem_rdata = tbl[i].rdata;
      bus.mem_byte_off = tbl[i].off; bus.mem_size = tbl[i].size; bus.mem_signed = tbl[i].sgn;
      tick;
      bus.mem_valid = 0;
      chk($sformatf("ld%0d_mis", i), load_misalign, tbl[i].mis);
      chk($sformatf("ld%0d_cnt", i), pending_cnt, tbl[i].mis ? 0 : 1);
      tick;
      chk($sformatf("ld%0d_we", i), RegWrite, !tbl[i].mis);
      chk($sformatf("ld%0d_mis_clr", i), load_misalign, 0);
      if (!tbl[i].mis) chk($sformatf("ld%0d_data", i), write_data, tbl[i].data);
    end
    tick;

    // stall fills the FIFO; third push waits
    wb_stall = 1;
    bus.alu_valid = 1; bus.alu_dest = 5'd1; bus.alu_result = 32'h0000_0001; tick;
    bus.alu_dest = 5'd2; bus.alu_result = 32'h0000_0002; tick;
    bus.alu_dest = 5'd3; bus.alu_result = 32'h0000_0003; #1;
    chk("stall_ready", bus.alu_ready, 0);
    chk("stall_mready", bus.mem_ready, 0);
    chk("stall_cnt", pending_cnt, 2);
    tick;
    chk("stall_we", RegWrite, 0);
    chk("stall_cnt2", pending_cnt, 2);
    wb_stall = 0; #1;
    chk("no_lookahead", bus.alu_ready, 0);
    tick;
    chk("rel_addr1", write_addr, 1);
    chk("rel_we1", RegWrite, 1);
    chk("rel_cnt1", pending_cnt, 1);
    tick;
    bus.alu_valid = 0;
    chk("rel_addr2", write_addr, 2);
    chk("rel_cnt2", pending_cnt, 1);
    tick;
    chk("rel_addr3", write_addr, 3);
    chk("rel_data3", write_data, 3);
    tick;
    chk("rel_idle", RegWrite, 0);

    // load beats ALU in the same cycle; $zero write suppressed
    wb_stall = 1;
    bus.alu_valid = 1; bus.alu_dest = 5'd7; bus.alu_result = 32'h7777_0007;
    bus.mem_valid = 1; bus.mem_dest = 5'd8; bus.mem_rdata = 32'h8888_0008;
    bus.mem_size = 2'b10; bus.mem_byte_off = 0; bus.mem_signed = 0; #1;
    chk("prio_alu_ready", bus.alu_ready, 0);
    chk("prio_mem_ready", bus.mem_ready, 1);
    tick;
    bus.mem_valid = 0;
    chk("prio_cnt1", pending_cnt, 1);
    tick;
    bus.alu_valid = 0;
    chk("prio_cnt2", pending_cnt, 2);
`ifdef WB_BYPASS_EN
    byp_addr_1 = 5'd8; byp_addr_2 = 5'd7; #1;
    chk("byp_hit8", byp_hit_1, 1);
    chk("byp_data8", byp_data_1, 32'h8888_0008);
    chk("byp_hit7", byp_hit_2, 1);
    chk("byp_data7", byp_data_2, 32'h7777_0007);
    byp_addr_2 = 5'd0; #1;
    chk("byp_zero_hit", byp_hit_2, 0);
    chk("byp_zero_data", byp_data_2, 0);
`endif
    wb_stall = 0;
    tick;
    chk("prio_first", write_addr, 8);
    chk("prio_first_d", write_data, 32'h8888_0008);
    tick;
    chk("prio_second", write_addr, 7);
    bus.alu_valid = 1; bus.alu_dest = 5'd0; bus.alu_result = 32'h0000_1234;
    tick;
    bus.alu_valid = 0;
    chk("zero_cnt", pending_cnt, 1);
    tick;
    chk("zero_we", RegWrite, 0);
    chk("zero_cnt0", pending_cnt, 0);
    chk("zero_hold", write_addr, 7);

    // randomized run against the queue model
    rst = 1; tick; rst = 0;
    q.delete(); exp_we = 0; exp_mis = 0; exp_addr = 0; exp_data = 0;
    for (int c = 0; c < 400; c++) begin
      bit full, mem_acc, alu_acc, pop;
      int off, size, align;
      ent_t e;
      wb_stall        = ($urandom_range(0, 3) == 0);
      bus.mem_valid   = ($urandom_range(0, 2) == 0);
      bus.alu_valid   = $urandom_range(0, 1);
      bus.mem_dest    = 5'($urandom_range(0, 7));
      bus.alu_dest    = 5'($urandom_range(0, 7));
      bus.mem_rdata   = $urandom;
      bus.alu_result  = $urandom;
      bus.mem_byte_off = 2'($urandom_range(0, 3));
      bus.mem_size    = 2'($urandom_range(0, 3));
      bus.mem_signed  = $urandom_range(0, 1);
`ifdef WB_BYPASS_EN
      byp_addr_1 = 5'($urandom_range(0, 7));
      byp_addr_2 = 5'($urandom_range(0, 7));
`endif
      #1;
      full = (q.size() >= DEPTH);
      chk("r_mem_ready", bus.mem_ready, !full);
      chk("r_alu_ready", bus.alu_ready, !full && !bus.mem_valid);
`ifdef WB_BYPASS_EN
      chk("r_byp1", {byp_hit_1, byp_data_1}, ref_byp(byp_addr_1));
      chk("r_byp2", {byp_hit_2, byp_data_2}, ref_byp(byp_addr_2));
`endif
      mem_acc = bus.mem_valid && !full;
      alu_acc = bus.alu_valid && !full && !bus.mem_valid;
      pop = !wb_stall && (q.size() > 0);
      exp_we = 0;
      if (pop) begin
        e = q.pop_front();
        if (e.d != 0) begin exp_we = 1; exp_addr = e.d; exp_data = e.v; end
      end
      off = int'(bus.mem_byte_off); size = int'(bus.mem_size);
      align = (size == 0) ? 1 : (size == 1) ? 2 : 4;
      exp_mis = mem_acc && (off % align != 0);
      if (mem_acc && !exp_mis)
        q.push_back('{bus.mem_dest, ref_ext(bus.mem_rdata, off, size, bus.mem_signed)});
      else if (alu_acc)
        q.push_back('{bus.alu_dest, bus.alu_result});
      tick;
      chk("r_we", RegWrite, exp_we);
      chk("r_addr", write_addr, exp_addr);
      chk("r_data", write_data, exp_data);
      chk("r_mis", load_misalign, exp_mis);
      chk("r_cnt", pending_cnt, q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
